csi2_tx_packetizer: RTL
=======================

// Module: csi2_tx_packetizer
// PURPOSE
//  2-lane MIPI CSI-2 packet transmitter: transmit side of the camera receive path.
//  Builds one full frame per request: FS short packet, LINES long packets from the pixel stream, FE short packet.
//  Drives per-lane HS byte streams to a downstream HS serializer / PHY.
//  Loopback target for the camera receiver.
// PARAMETERS
//  LINE_BYTES  1280    payload bytes per line (WC); must be even, 2..65534; elaboration error otherwise
//  LINES       480     long packets per frame, 1..65535
//  DATA_TYPE   6'h22   long-packet DT (RGB565)
//  VC          2'd0    virtual channel for all packets
//  LP_GAP      8       cycles of hs_en=0 between packets, >=1
// PORTS
//  clk          in   1   byte clock; all logic on posedge
//  resetn       in   1   asynchronous, active-low reset
//  frame_start  in   1   single-cycle request to send one frame
//  pix_data     in   16  payload bytes; [7:0] is the earlier byte
//  pix_valid    in   1   pix_data valid
//  pix_ready    out  1   payload byte pair consumed this cycle
//  hs_en        out  1   lanes in HS mode; lane_data meaningful
//  lane_data    out  16  lane0=[7:0], lane1=[15:8]
//  busy         out  1   frame in progress
//  frame_done   out  1   one-cycle pulse after last FE byte
//  underrun     out  1   sticky: payload byte missing in a frame; cleared on accepted frame_start
//  frame_num    out  16  frame number carried in the current/last FS/FE
// BEHAVIOUR
//  Reset: hs_en=0, lane_data=0, pix_ready=0, busy=0, frame_done=0, underrun=0, frame_num=0; FSM=IDLE.
//  Mid-frame reset aborts immediately; no FE is sent.
//  Packet byte order on the wire: DI={VC,DT}, WC[7:0], WC[15:8], ECC, [payload], [CRC[7:0], CRC[15:8]].
//  Bytes alternate lane0, lane1: each cycle carries 2 consecutive bytes.
//  FSM states: IDLE -> SYNC -> HDR0 -> HDR1 -> [PAYLOAD -> CRC] -> GAP -> SYNC ... -> IDLE.
//   IDLE: frame_start=1 -> SYNC next cycle; busy=1.
//    frame_num increments modulo 65536, skipping 0 (1..65535, 65535->1); underrun cleared.
//    frame_start while busy is ignored.
//   SYNC: hs_en=1, lane_data=16'hB8B8 (1 cycle).
//   HDR0: {WC[7:0], DI}.
//   HDR1: {ECC, WC[15:8]}.
//    FS/FE: DT 0x00/0x01, WC=frame_num; go to GAP.
//    Long packet: WC=LINE_BYTES; go to PAYLOAD.
//   PAYLOAD: exactly LINE_BYTES/2 cycles; pix_ready=1 every cycle (HS burst cannot stall).
//    pix_valid=1 -> lane_data=pix_data.
//    pix_valid=0 -> lane_data=16'h0000, underrun<=1; byte still counts and enters CRC.
//   CRC: {CRC[15:8], CRC[7:0]} on lanes {1,0}; 1 cycle; go to GAP.
//   GAP: hs_en=0, lane_data=0 for LP_GAP cycles, then SYNC of next packet.
//    Gap after FE -> IDLE; frame_done pulses on the FE-gap's last cycle; busy drops the next cycle.
//  Packet order: FS, line 0..LINES-1, FE. Line counter wraps to 0 at frame end.
//  ECC: CSI-2 6-bit Hamming over {WC[15:0], DI} (24 bits); ECC[7:6]=0.
//  CRC: CSI-2 CRC-16 (poly x^16+x^12+x^5+1, reflected 0x8408), seed 16'hFFFF, LSB-first.
//   Over payload only, 2 bytes/cycle, lane0 byte first; reseeded at each HDR1.
//  Frame length in cycles: 3*(1+2+LP_GAP) + LINES*(1+2+LINE_BYTES/2+1+LP_GAP) - 2*(1+2+LP_GAP) - LINES*(...)?
//   No: total = 2*(3+LP_GAP) + LINES*(4+LINE_BYTES/2+LP_GAP), IDLE exit to frame_done inclusive.
//  All outputs registered; lane_data/hs_en change only on clk edge.
// STRUCTURE
//  Package csi2_pkg:
//   DT constants (DT_FS=0x00, DT_FE=0x01, DT_LS=0x02, DT_LE=0x03, DT_RGB565=0x22).
//   SYNC_BYTE=0xB8.
//   function csi2_ecc(input [23:0] hdr) -> [5:0].
//   function csi2_crc_byte(input [15:0] crc, input [7:0] d) -> [15:0].
//  Sub-module csi2_crc16: clk, resetn, init, en, d[15:0] -> crc[15:0].
//   Two chained csi2_crc_byte steps per cycle.
//  Top holds FSM, gap/byte/line counters, frame_num.
// TESTING
//  1. CRC unit, seed FFFF, bytes FF 00 00 02 B9 DC F3 72 BB D4 B8 5A C8 75 C2 7C 81 F8 05 DF FF 00 00 01
//     -> crc=16'h00F0.
//  2. LINE_BYTES=4, LINES=2, LP_GAP=2; frame_start after reset:
//     - next cycle hs_en=1, lane_data=B8B8;
//     - then 16'h0100, {ecc,8'h00}; FS WC=1, frame_num=1;
//     - total cycles to frame_done = 2*5 + 2*8 = 26.
//  3. Loopback through lane serializer into camera receiver, 640x480 RGB565 ramp:
//     - frame_start, 480 valid_packet with DT 0x22;
//     - frame_end seen; underrun=0.
//  4. pix_valid held 0 for one PAYLOAD cycle -> lanes carry 0000, underrun=1 stays set;
//     CRC matches model with zeros; next frame_start clears underrun.
//  5. frame_start pulsed while busy -> ignored, frame_num unchanged.
//     frame_num preset to 65535 -> next frame carries WC=1.
//  6. resetn low during PAYLOAD -> hs_en=0, busy=0, pix_ready=0 asynchronously.
//     Next frame_start starts cleanly with SYNC.

Source files
------------

// File: rtl/csi2_pkg.sv
// csi2_pkg: CSI-2 packet constants, FSM/packet types and the ECC/CRC helpers
// shared by the packetizer and its CRC unit.
package csi2_pkg;
    localparam logic [5:0] DT_FS = 6'h00;
    localparam logic [5:0] DT_FE = 6'h01;
    localparam logic [5:0] DT_LS = 6'h02;
    localparam logic [5:0] DT_LE = 6'h03;
    localparam logic [5:0] DT_RGB565 = 6'h22;
    localparam logic [7:0] SYNC_BYTE = 8'hB8;
    localparam logic [15:0] CRC_SEED = 16'hFFFF;

    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_HDR0, S_HDR1, S_PAYLOAD, S_CRC, S_GAP} state_t;
    typedef enum logic [1:0] {P_FS, P_LINE, P_FE} pkt_t;

    // Each mask selects the header bits covered by one Hamming parity bit.
    function automatic logic [5:0] csi2_ecc(input logic [23:0] hdr);
        return {^(hdr & 24'hEFFC00), ^(hdr & 24'hDF03F0), ^(hdr & 24'hB8E38E),
                ^(hdr & 24'h749A6D), ^(hdr & 24'hF2555B), ^(hdr & 24'hF12CB7)};
    endfunction

    function automatic logic [15:0] csi2_crc_byte(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        c = crc ^ {8'h00, d};
        for (int i = 0; i < 8; i++) c = c[0] ? (c >> 1) ^ 16'h8408 : c >> 1;
        return c;
    endfunction
endpackage

// File: rtl/csi2_crc16.sv
// csi2_crc16: CSI-2 payload CRC-16, two bytes per cycle, low byte first.
// init together with en restarts from the seed and folds in the current pair.
module csi2_crc16
    import csi2_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        init,
    input  logic        en,
    input  logic [15:0] d,
    output logic [15:0] crc
);
    logic [15:0] r_crc;
    logic [15:0] w_base;

    always_comb w_base = init ? CRC_SEED : r_crc;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_crc <= CRC_SEED;
        else if (en) r_crc <= csi2_crc_byte(csi2_crc_byte(w_base, d[7:0]), d[15:8]);
        else if (init) r_crc <= CRC_SEED;
    end

    assign crc = r_crc;
endmodule

// File: rtl/csi2_tx_packetizer.sv
// csi2_tx_packetizer: 2-lane CSI-2 frame transmitter (FS, LINES long packets, FE).
// Outputs are registered for the state being entered, so lanes follow the FSM exactly.
module csi2_tx_packetizer
    import csi2_pkg::*;
#(
    parameter int          LINE_BYTES     = 1280,
    parameter int          LINES          = 480,
    parameter logic [5:0]  DATA_TYPE      = DT_RGB565,
    parameter logic [1:0]  VC             = 2'd0,
    parameter int          LP_GAP         = 8,
    parameter logic [15:0] FRAME_NUM_INIT = 16'd0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        frame_start,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        hs_en,
    output logic [15:0] lane_data,
    output logic        busy,
    output logic        frame_done,
    output logic        underrun,
    output logic [15:0] frame_num
);
    localparam int W = LINE_BYTES / 2;

    if (LINE_BYTES < 2 || LINE_BYTES > 65534 || LINE_BYTES % 2 != 0) begin : g_bad_lb
        $error("LINE_BYTES must be even and in 2..65534");
    end
    if (LINES < 1 || LINES > 65535) begin : g_bad_lines
        $error("LINES must be in 1..65535");
    end
    if (LP_GAP < 1 || LP_GAP > 65536) begin : g_bad_gap
        $error("LP_GAP must be in 1..65536");
    end

    state_t      r_state;
    pkt_t        r_pkt;
    logic [15:0] r_cnt;
    logic [15:0] r_line;
    logic [15:0] r_fn;
    logic        r_hs;
    logic [15:0] r_lane;
    logic        r_ready;
    logic        r_busy;
    logic        r_done;
    logic        r_underrun;

    logic [5:0]  w_dt;
    logic [15:0] w_wc;
    logic [7:0]  w_di;
    logic [5:0]  w_ecc;
    logic [15:0] w_word;
    logic [15:0] w_crc;
    logic        w_last_line;

    always_comb begin
        w_dt = r_pkt == P_FS ? DT_FS : r_pkt == P_FE ? DT_FE : DATA_TYPE;
        w_wc = r_pkt == P_LINE ? 16'(LINE_BYTES) : r_fn;
        w_di = {VC, w_dt};
        w_ecc = csi2_ecc({w_wc, w_di});
        w_word = pix_valid ? pix_data : 16'h0000;
        w_last_line = int'(r_line) == LINES - 1;
    end

    csi2_crc16 u_crc (
        .clk   (clk),
        .resetn(resetn),
        .init  (r_state == S_HDR1),
        .en    (r_ready),
        .d     (w_word),
        .crc   (w_crc)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_pkt <= P_FS;
            r_cnt <= '0;
            r_line <= '0;
            r_fn <= FRAME_NUM_INIT;
            r_hs <= 1'b0;
            r_lane <= '0;
            r_ready <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_ready && !pix_valid) r_underrun <= 1'b1;
            case (r_state)
                S_IDLE: if (frame_start) begin
                    r_state <= S_SYNC;
                    r_pkt <= P_FS;
                    r_line <= '0;
                    r_busy <= 1'b1;
                    r_hs <= 1'b1;
                    r_lane <= {2{SYNC_BYTE}};
                    r_fn <= r_fn == 16'hFFFF ? 16'd1 : r_fn + 16'd1;
                    r_underrun <= 1'b0;
                end
                S_SYNC: begin
                    r_state <= S_HDR0;
                    r_lane <= {w_wc[7:0], w_di};
                end
                // Payload is accepted one cycle ahead of the lanes, so ready rises here.
                S_HDR0: begin
                    r_state <= S_HDR1;
                    r_lane <= {2'b00, w_ecc, w_wc[15:8]};
                    r_ready <= r_pkt == P_LINE;
                end
                S_HDR1: begin
                    r_cnt <= '0;
                    if (r_pkt == P_LINE) begin
                        r_state <= S_PAYLOAD;
                        r_lane <= w_word;
                        r_ready <= W > 1;
                    end else begin
                        r_state <= S_GAP;
                        r_hs <= 1'b0;
                        r_lane <= '0;
                        r_done <= r_pkt == P_FE && LP_GAP == 1;
                    end
                end
                S_PAYLOAD: if (int'(r_cnt) == W - 1) begin
                    r_state <= S_CRC;
                    r_lane <= w_crc;
                end else begin
                    r_cnt <= r_cnt + 16'd1;
                    r_lane <= w_word;
                    r_ready <= int'(r_cnt) + 2 < W;
                end
                S_CRC: begin
                    r_state <= S_GAP;
                    r_cnt <= '0;
                    r_hs <= 1'b0;
                    r_lane <= '0;
                end
                S_GAP: if (int'(r_cnt) == LP_GAP - 1) begin
                    r_state <= r_pkt == P_FE ? S_IDLE : S_SYNC;
                    r_busy <= r_pkt != P_FE;
                    r_hs <= r_pkt != P_FE;
                    r_lane <= r_pkt == P_FE ? 16'h0000 : {2{SYNC_BYTE}};
                    r_pkt <= r_pkt == P_LINE && w_last_line ? P_FE : P_LINE;
                    r_line <= r_pkt == P_LINE && !w_last_line ? r_line + 16'd1 : '0;
                end else begin
                    r_cnt <= r_cnt + 16'd1;
                    r_done <= r_pkt == P_FE && int'(r_cnt) + 2 == LP_GAP;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign pix_ready = r_ready;
    assign hs_en = r_hs;
    assign lane_data = r_lane;
    assign busy = r_busy;
    assign frame_done = r_done;
    assign underrun = r_underrun;
    assign frame_num = r_fn;
endmodule
